// File: rtl/lieat_general_skidbuf.sv
// rtl/lieat_general_skidbuf.sv - two-entry skid buffer with registered valid and ready paths
// Optional synchronous flush port enabled by LIEAT_SKIDBUF_FLUSH_EN.
module lieat_general_skidbuf #(
  parameter int DW   = 32,
  parameter bit MASK = 1'b0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_valid,
  output logic          i_ready,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [DW-1:0] o_data,
  output logic [1:0]    o_count
`ifdef LIEAT_SKIDBUF_FLUSH_EN
  ,
  input  logic          flush
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [DW-1:0] m_q;
  logic [DW-1:0] s_q;
  logic          in_hs;
  logic          out_hs;
  logic          load_m_in;
  logic          load_m_skid;
  logic          load_s;

  assign in_hs  = i_valid & i_ready;
  assign out_hs = o_valid & o_ready;

  always_comb begin
    state_d     = state_q;
    load_m_in   = 1'b0;
    load_m_skid = 1'b0;
    load_s      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_hs) begin
          load_m_in = 1'b1;
          state_d   = ONE;
        end
      end
      ONE: begin
        if (in_hs && out_hs) begin
          load_m_in = 1'b1;
        end else if (in_hs) begin
          load_s  = 1'b1;
          state_d = FULL;
        end else if (out_hs) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_hs) begin
          load_m_skid = 1'b1;
          state_d     = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
`ifdef LIEAT_SKIDBUF_FLUSH_EN
    // Flush wins over any same-cycle handshake; the presented beat is dropped.
    if (flush) begin
      state_d     = EMPTY;
      load_m_in   = 1'b0;
      load_m_skid = 1'b0;
      load_s      = 1'b0;
    end
`endif
  end

  // Ready and valid are registered from the next state so neither is combinational.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= EMPTY;
      i_ready <= 1'b1;
      o_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      i_ready <= (state_d != FULL);
      o_valid <= (state_d != EMPTY);
    end
  end

  always_ff @(posedge clk) begin
    if (load_m_in) begin
      m_q <= i_data;
    end else if (load_m_skid) begin
      m_q <= s_q;
    end
    if (load_s) begin
      s_q <= i_data;
    end
  end

  assign o_data = (MASK && !o_valid) ? '0 : m_q;

  always_comb begin
    case (state_q)
      ONE:     o_count = 2'd1;
      FULL:    o_count = 2'd2;
      default: o_count = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_lieat_general_skidbuf.sv
// tb/tb_lieat_general_skidbuf.sv - queue-model testbench for lieat_general_skidbuf
module tb_lieat_general_skidbuf;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          i_valid = 1'b0;
  logic          i_ready;
  logic [DW-1:0] i_data = '0;
  logic          o_valid;
  logic          o_ready = 1'b0;
  logic [DW-1:0] o_data;
  logic [1:0]    o_count;
`ifdef LIEAT_SKIDBUF_FLUSH_EN
  logic          flush = 1'b0;
`endif

  int n_pass  = 0;
  int n_total = 0;
  int pushed  = 0;
  bit check_en = 1'b0;

  logic [DW-1:0] q[$];
  bit            stall_prev = 1'b0;
  logic [DW-1:0] data_prev;

  lieat_general_skidbuf #(.DW(DW), .MASK(1'b1)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_count (o_count)
`ifdef LIEAT_SKIDBUF_FLUSH_EN
    ,
    .flush   (flush)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: a FIFO of at most two beats; ready means room, valid means non-empty.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q.delete();
      stall_prev = 1'b0;
    end else begin
      bit do_pop;
      bit do_push;
      stall_prev = o_valid && !o_ready;
      data_prev  = o_data;
      do_pop  = (q.size() > 0) && o_ready;
      do_push = i_valid && (q.size() < 2);
`ifdef LIEAT_SKIDBUF_FLUSH_EN
      if (flush) begin
        q.delete();
        do_pop  = 1'b0;
        do_push = 1'b0;
      end
`endif
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back(i_data);
        pushed++;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en && rstn) begin
      check("i_ready", {31'd0, i_ready}, {31'd0, q.size() < 2});
      check("o_valid", {31'd0, o_valid}, {31'd0, q.size() > 0});
      check("o_count", {30'd0, o_count}, q.size());
      check("o_data", {16'd0, o_data}, (q.size() > 0) ? {16'd0, q[0]} : 32'd0);
      if (stall_prev && o_valid) check("stall_hold", {16'd0, o_data}, {16'd0, data_prev});
    end
  end

  task automatic drive(input bit v, input logic [DW-1:0] d, input bit r);
    i_valid = v;
    i_data  = d;
    o_ready = r;
  endtask

  initial begin
    logic [DW-1:0] stream [3];
    stream[0] = 16'h11; stream[1] = 16'h22; stream[2] = 16'h33;

    repeat (3) @(negedge clk);
    check("rst_i_ready", {31'd0, i_ready}, 32'd1);
    check("rst_o_valid", {31'd0, o_valid}, 32'd0);
    check("rst_o_count", {30'd0, o_count}, 32'd0);
    check("rst_o_data", {16'd0, o_data}, 32'd0);
    rstn = 1'b1;
    check_en = 1'b1;

    // Streaming: one beat per cycle, count stays at one.
    drive(1'b1, stream[0], 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stream_data", {16'd0, o_data}, {16'd0, stream[i]});
      check("stream_count", {30'd0, o_count}, 32'd1);
      if (i < 2) drive(1'b1, stream[i+1], 1'b1);
      else drive(1'b0, '0, 1'b1);
    end
    @(negedge clk);
    check("stream_empty", {31'd0, o_valid}, 32'd0);

    // Skid: two beats absorbed under backpressure.
    drive(1'b1, 16'hA1, 1'b0);
    @(negedge clk);
    check("skid1_count", {30'd0, o_count}, 32'd1);
    drive(1'b1, 16'hA2, 1'b0);
    @(negedge clk);
    check("skid2_count", {30'd0, o_count}, 32'd2);
    check("skid2_ready", {31'd0, i_ready}, 32'd0);
    check("skid2_data", {16'd0, o_data}, 32'hA1);
    drive(1'b0, '0, 1'b0);
    @(negedge clk);
    check("skid_hold", {16'd0, o_data}, 32'hA1);
    drive(1'b0, '0, 1'b1);
    @(negedge clk);
    check("skid_drain_data", {16'd0, o_data}, 32'hA2);
    check("skid_ready_back", {31'd0, i_ready}, 32'd1);
    @(negedge clk);
    check("skid_drained", {31'd0, o_valid}, 32'd0);

    // Random stall traffic.
    pushed = 0;
    for (int c = 0; c < 20000 && pushed < 1000; c++) begin
      drive(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 3) != 0 ? 1 : 0));
      @(negedge clk);
    end
    check("random_beats", {31'd0, pushed >= 1000}, 32'd1);
    drive(1'b0, '0, 1'b1);
    repeat (3) @(negedge clk);

    // Reset mid-operation with two beats stored.
    drive(1'b1, 16'hB1, 1'b0);
    @(negedge clk);
    drive(1'b1, 16'hB2, 1'b0);
    @(negedge clk);
    check("pre_rst_count", {30'd0, o_count}, 32'd2);
    drive(1'b0, '0, 1'b0);
    rstn = 1'b0;
    #1;
    check("arst_i_ready", {31'd0, i_ready}, 32'd1);
    check("arst_o_valid", {31'd0, o_valid}, 32'd0);
    check("arst_o_count", {30'd0, o_count}, 32'd0);
    check("arst_o_data", {16'd0, o_data}, 32'd0);
    #2;
    rstn = 1'b1;
    @(negedge clk);
    drive(1'b1, 16'h5A, 1'b1);
    @(negedge clk);
    check("post_rst_data", {16'd0, o_data}, 32'h5A);
    check("post_rst_count", {30'd0, o_count}, 32'd1);
    drive(1'b0, '0, 1'b1);
    @(negedge clk);
    check("post_rst_alone", {31'd0, o_valid}, 32'd0);

`ifdef LIEAT_SKIDBUF_FLUSH_EN
    drive(1'b1, 16'hC1, 1'b0);
    @(negedge clk);
    drive(1'b1, 16'hC2, 1'b0);
    @(negedge clk);
    drive(1'b1, 16'h77, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_valid", {31'd0, o_valid}, 32'd0);
    check("flush_count", {30'd0, o_count}, 32'd0);
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("flush_no77", {31'd0, o_valid && (o_data == 16'h77)}, 32'd0);
    end
`endif

    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
